rv16_mem_arbiter: RTL and testbench

- Shares one single-port, 16-bit word-addressed RAM between the rv16r instruction-fetch port (I) and the load/store port (D).
- Sits between the core and the unified program/data memory. That memory is still loaded by $readmemh into its `ram` array, so no load port is needed here.
- Grants at most one access per cycle. Data requests have priority, bounded by a starvation guard that protects fetch.
- Read responses are routed back to the owning requester one cycle after the grant.

---
 rtl/rv16_mem_arbiter_if.sv | 38 +++
 rtl/rv16_mem_arbiter.sv | 111 +++++++++++
 tb/tb_rv16_mem_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/rv16_mem_arbiter_if.sv
// Bus bundle between the rv16r fetch/load-store ports, the arbiter and the shared RAM.
// The slave view is the arbiter. The master view is the core plus the RAM.
interface rv16_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/rv16_mem_arbiter.sv
// Single-port RAM arbiter for rv16r: D has priority, I is protected by a bounded D-run
// counter. Read data is steered back to the owner one cycle after the grant.
module rv16_mem_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned MAX_D_RUN = 4
) (
    input logic               clk,
    input logic               rst,
    rv16_mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRspI, StRspD} rsp_state_e;

    localparam logic [3:0] MaxRun = 4'(MAX_D_RUN);

    rsp_state_e state_q, state_d;
    logic [3:0] run_cnt_q, run_cnt_d;
    logic       rsp_we_q, rsp_we_d;
    logic       grant_i, grant_d;

    // D wins contention until it has taken MAX_D_RUN grants in a row over a waiting I.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            if (bus.d_req && !(bus.i_req && (run_cnt_q == MaxRun))) begin
                grant_d = 1'b1;
            end else if (bus.i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    always_comb begin
        bus.i_gnt = grant_i;
        bus.d_gnt = grant_d;
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (grant_d) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
        end else if (grant_i) begin
            bus.mem_en   = 1'b1;
            bus.mem_addr = bus.i_addr;
        end
    end

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (grant_i || !bus.i_req) begin
            run_cnt_d = 4'd0;
        end else if (grant_d && (run_cnt_q != MaxRun)) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end
    end

    always_comb begin
        state_d  = StIdle;
        rsp_we_d = 1'b0;
        if (grant_i) begin
            state_d = StRspI;
        end else if (grant_d) begin
            state_d  = StRspD;
            rsp_we_d = bus.d_we;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            run_cnt_q <= 4'd0;
            rsp_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_cnt_q <= run_cnt_d;
            rsp_we_q  <= rsp_we_d;
        end
    end

    // Gating with rst drops a response whose grant happened just before reset.
    always_comb begin
        bus.i_rvalid = 1'b0;
        bus.i_rdata  = '0;
        bus.d_rvalid = 1'b0;
        bus.d_rdata  = '0;
        if (!rst) begin
            case (state_q)
                StRspI: begin
                    bus.i_rvalid = 1'b1;
                    bus.i_rdata  = bus.mem_rdata;
                end
                StRspD: begin
                    bus.d_rvalid = 1'b1;
                    bus.d_rdata  = rsp_we_q ? '0 : bus.mem_rdata;
                end
                default: ;
            endcase
        end
    end

    grant_onehot_a: assert property (@(posedge clk) !(bus.i_gnt && bus.d_gnt));
    i_gnt_needs_req_a: assert property (@(posedge clk) bus.i_gnt |-> bus.i_req);
    d_gnt_needs_req_a: assert property (@(posedge clk) bus.d_gnt |-> bus.d_req);
endmodule

// File: tb/tb_rv16_mem_arbiter.sv
// Directed bench for rv16_mem_arbiter with a write-first, 1-cycle-latency RAM model.
module tb_rv16_mem_arbiter;
    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;
    localparam int unsigned MAXR = 4;

    typedef struct {
        logic        rst;
        logic        ireq;
        logic [15:0] iaddr;
        logic        dreq;
        logic        dwe;
        logic [15:0] daddr;
        logic [15:0] dwdata;
        logic        eig;
        logic        edg;
        logic        eiv;
        logic [15:0] eird;
        logic        edv;
        logic [15:0] edrd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    rv16_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    rv16_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(MAXR)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [15:0] ram [0:65535];

    always @(posedge clk) begin
        if (bus.mem_en) begin
            if (bus.mem_we) begin
                ram[bus.mem_addr] <= bus.mem_wdata;
                bus.mem_rdata     <= bus.mem_wdata;
            end else begin
                bus.mem_rdata <= ram[bus.mem_addr];
            end
        end
    end

    function automatic vec_t mk(logic r, logic ir, logic [15:0] ia, logic dr, logic dw,
                                logic [15:0] da, logic [15:0] dd, logic eig, logic edg,
                                logic eiv, logic [15:0] eird, logic edv, logic [15:0] edrd);
        vec_t v;
        v.rst = r;    v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw;
        v.daddr = da; v.dwdata = dd;
        v.eig = eig;  v.edg = edg; v.eiv = eiv; v.eird = eird; v.edv = edv; v.edrd = edrd;
        return v;
    endfunction

    task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        @(negedge clk);
        rst         = v.rst;
        bus.i_req   = v.ireq;
        bus.i_addr  = v.iaddr;
        bus.d_req   = v.dreq;
        bus.d_we    = v.dwe;
        bus.d_addr  = v.daddr;
        bus.d_wdata = v.dwdata;
        #1;
    endtask

    // Expected RAM drive is derived from the expected grant and the applied inputs.
    task automatic check(string tag, vec_t v);
        logic [15:0] eaddr;
        eaddr = v.edg ? v.daddr : (v.eig ? v.iaddr : 16'h0);
        chk({tag, ".i_gnt"},     16'(bus.i_gnt),    16'(v.eig));
        chk({tag, ".d_gnt"},     16'(bus.d_gnt),    16'(v.edg));
        chk({tag, ".i_rvalid"},  16'(bus.i_rvalid), 16'(v.eiv));
        chk({tag, ".i_rdata"},   bus.i_rdata,       v.eird);
        chk({tag, ".d_rvalid"},  16'(bus.d_rvalid), 16'(v.edv));
        chk({tag, ".d_rdata"},   bus.d_rdata,       v.edrd);
        chk({tag, ".mem_en"},    16'(bus.mem_en),   16'(v.eig | v.edg));
        chk({tag, ".mem_we"},    16'(bus.mem_we),   16'(v.edg & v.dwe));
        chk({tag, ".mem_addr"},  bus.mem_addr,      eaddr);
        chk({tag, ".mem_wdata"}, bus.mem_wdata,     v.edg ? v.dwdata : 16'h0);
    endtask

    initial begin
        int ireq5[8];
        int edg5[8];
        vec_t v;

        for (int a = 0; a < 65536; a++) ram[a] = (a < 256) ? 16'(16'h1000 + a) : 16'h0;
        ram[16'hFFFF] = 16'h5A5A;
        bus.mem_rdata = '0;
        rst = 1'b1;
        bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0;

        //           rst ir ia     dr dw da      dd       ig dg iv ird      dv rdd
        // reset with both requesting, then first cycle after release
        vecs.push_back(mk(1, 1, 16'h0, 1, 0, 16'h10, 16'h0, 0, 0, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(1, 1, 16'h0, 1, 0, 16'h10, 16'h0, 0, 0, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(1, 1, 16'h0, 1, 0, 16'h10, 16'h0, 0, 0, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(0, 1, 16'h0, 1, 0, 16'h10, 16'h0, 0, 1, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0,  16'h0, 0, 0, 0, 16'h0, 1, 16'h1010));
        // fetch stream
        vecs.push_back(mk(0, 1, 16'h0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0,    0, 16'h0));
        vecs.push_back(mk(0, 1, 16'h1, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h1000, 0, 16'h0));
        vecs.push_back(mk(0, 1, 16'h2, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h1001, 0, 16'h0));
        vecs.push_back(mk(0, 1, 16'h3, 0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h1002, 0, 16'h0));
        vecs.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 16'h1003, 0, 16'h0));
        // store then load same address
        vecs.push_back(mk(0, 0, 16'h0, 1, 1, 16'h40, 16'hBEEF, 0, 1, 0, 16'h0, 0, 16'h0));
        vecs.push_back(mk(0, 0, 16'h0, 1, 0, 16'h40, 16'h0,    0, 1, 0, 16'h0, 1, 16'h0));
        vecs.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0,  16'h0,    0, 0, 0, 16'h0, 1, 16'hBEEF));
        // contention: D D D D I D D D D I D D
        vecs.push_back(mk(0, 1, 16'h5, 1, 0, 16'h20, 16'h0, 0, 1, 0, 16'h0,    0, 16'h0));
        vecs.push_back(mk(0, 1, 16'h5, 1, 0, 16'h20, 16'h0, 0, 1, 0, 16'h0,    1, 16'h1020));
        vecs.push_back(mk(0, 1, 16'h5, 1, 0, 16'h20, 16'h0, 0, 1, 0, 16'h0,    1, 16'h1020));
        vecs.push_back(mk(0, 1, 16'h5, 1, 0, 16'h20, 16'h0, 0, 1, 0, 16'h0,    1, 16'h1020));
        vecs.push_back(mk(0, 1, 16'h5, 1, 0, 16'h20, 16'h0, 1, 0, 0, 16'h0,    1, 16'h1020));
        vecs.push_back(mk(0, 1, 16'h5, 1, 0, 16'h20, 16'h0, 0, 1, 1, 16'h1005, 0, 16'h0));
        vecs.push_back(mk(0, 1, 16'h5, 1, 0, 16'h20, 16'h0, 0, 1, 0, 16'h0,    1, 16'h1020));
        vecs.push_back(mk(0, 1, 16'h5, 1, 0, 16'h20, 16'h0, 0, 1, 0, 16'h0,    1, 16'h1020));
        vecs.push_back(mk(0, 1, 16'h5, 1, 0, 16'h20, 16'h0, 0, 1, 0, 16'h0,    1, 16'h1020));
        vecs.push_back(mk(0, 1, 16'h5, 1, 0, 16'h20, 16'h0, 1, 0, 0, 16'h0,    1, 16'h1020));
        vecs.push_back(mk(0, 1, 16'h5, 1, 0, 16'h20, 16'h0, 0, 1, 1, 16'h1005, 0, 16'h0));
        vecs.push_back(mk(0, 1, 16'h5, 1, 0, 16'h20, 16'h0, 0, 1, 0, 16'h0,    1, 16'h1020));
        vecs.push_back(mk(0, 0, 16'h0, 0, 0, 16'h0,  16'h0, 0, 0, 0, 16'h0,    1, 16'h1020));

        foreach (vecs[k]) begin
            drive(vecs[k]);
            check($sformatf("vec%0d", k), vecs[k]);
        end

        // A dropped i_req clears the run counter: I then waits a full MAX_D_RUN again.
        ireq5 = '{1, 1, 0, 1, 1, 1, 1, 1};
        edg5  = '{1, 1, 1, 1, 1, 1, 1, 0};
        for (int k = 0; k < 8; k++) begin
            logic pd;
            pd = (k > 0) && (edg5[k-1] != 0);
            v = mk(0, ireq5[k] != 0, 16'h7, 1, 0, 16'h30, 16'h0,
                   edg5[k] == 0, edg5[k] != 0,
                   (k > 0) && !pd, 16'h0, pd, pd ? 16'h1030 : 16'h0);
            drive(v);
            check($sformatf("run%0d", k), v);
        end
        v = mk(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 1, 16'h1007, 0, 16'h0);
        drive(v);
        check("run_tail", v);

        // Reset right after a load grant to the top address drops its response.
        v = mk(0, 0, 16'h0, 1, 0, 16'hFFFF, 16'h0, 0, 1, 0, 16'h0, 0, 16'h0);
        drive(v);
        check("rst_grant", v);
        v = mk(1, 1, 16'h0, 1, 0, 16'hFFFF, 16'h0, 0, 0, 0, 16'h0, 0, 16'h0);
        drive(v);
        check("rst_cyc0", v);
        drive(v);
        check("rst_cyc1", v);
        v = mk(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0, 16'h0);
        drive(v);
        check("rst_after", v);
        v = mk(0, 0, 16'h0, 1, 0, 16'hFFFF, 16'h0, 0, 1, 0, 16'h0, 0, 16'h0);
        drive(v);
        check("reissue", v);
        v = mk(0, 0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 1, 16'h5A5A);
        drive(v);
        check("reissue_rsp", v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
